// File: rtl/simon_round_engine_if.sv
// Block-level bus for the SIMON round engine: plaintext input handshake,
// round-key stream, ciphertext output handshake and the busy status.
interface simon_round_engine_if #(
  parameter int N = 16
) ();

  // Plaintext block input
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_x;
  logic [N-1:0] in_y;

  // Round-key stream, one key per executed round
  logic         key_valid;
  logic         key_ready;
  logic [N-1:0] key;

  // Ciphertext output
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x;
  logic [N-1:0] out_y;

  // Status
  logic         busy;

  // Upstream/downstream side: drives blocks, keys and output back-pressure.
  modport master (
    output in_valid, in_x, in_y,
    output key_valid, key,
    output out_ready,
    input  in_ready, key_ready, out_valid, out_x, out_y, busy
  );

  // Engine side.
  modport slave (
    input  in_valid, in_x, in_y,
    input  key_valid, key,
    input  out_ready,
    output in_ready, key_ready, out_valid, out_x, out_y, busy
  );

endinterface

// File: rtl/simon_round_engine.sv
// Iterative SIMON encryption engine. One round per clock from registered
// x/y and the presented round key; IDLE -> RUN -> DONE control with
// valid/ready handshakes on the block input, key stream and ciphertext.
module simon_round_engine #(
  parameter int N      = 16,
  parameter int ROUNDS = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  simon_round_engine_if.slave    bus
);

  // Round counter is wide enough for ROUNDS-1, never narrower than one bit.
  localparam int              RW       = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0]   LAST_RND = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [N-1:0]  x_next;
  logic [N-1:0]  y_next;
  logic [RW-1:0] rnd;
  logic [RW-1:0] rnd_next;
  logic [N-1:0]  f_x;
  logic [N-1:0]  round_x;

  // Left rotations used by the SIMON round function.
  function automatic logic [N-1:0] rot1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  function automatic logic [N-1:0] rot2(input logic [N-1:0] v);
    return {v[N-3:0], v[N-1:N-2]};
  endfunction

  function automatic logic [N-1:0] rot8(input logic [N-1:0] v);
    return {v[N-9:0], v[N-1:N-8]};
  endfunction

  // Round function on the current x and the candidate new x for this round.
  always_comb begin
    f_x     = (rot1(x) & rot8(x)) ^ rot2(x);
    round_x = y ^ f_x ^ bus.key;
  end

  // Next-state, datapath-update and handshake decode for the control FSM.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    x_next        = x;
    y_next        = y;
    rnd_next      = rnd;
    bus.in_ready  = 1'b0;
    bus.key_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;

    unique case (state)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          x_next     = bus.in_x;
          y_next     = bus.in_y;
          rnd_next   = '0;
          state_next = S_RUN;
        end
      end

      S_RUN: begin
        bus.key_ready = 1'b1;
        bus.busy      = 1'b1;
        // Without a key the round simply does not happen: all state holds.
        if (bus.key_valid) begin
          x_next = round_x;
          y_next = x;
          if (rnd == LAST_RND) begin
            state_next = S_DONE;
          end else begin
            rnd_next = rnd + 1'b1;
          end
        end
      end

      S_DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, block and round-counter registers with synchronous reset.
  // NOTE: x/y are reset as well as the FSM, because out_x/out_y drive them
  // directly and must read zero straight after reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others (y takes the old x).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      rnd   <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      y     <= y_next;
      rnd   <= rnd_next;
    end
  end

  assign bus.out_x = x;
  assign bus.out_y = y;

endmodule

// File: tb/tb_simon_round_engine.sv
// Self-checking bench for simon_round_engine: a Simon32/64 engine driven
// from a vector table with a scoreboard queue, plus a ROUNDS=1 instance
// and hand-written reset / back-pressure / back-to-back sequences.
module tb_simon_round_engine;

  localparam int N      = 16;
  localparam int ROUNDS = 32;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  simon_round_engine_if #(.N(N)) b   ();
  simon_round_engine_if #(.N(N)) one ();

  simon_round_engine #(.N(N), .ROUNDS(ROUNDS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  simon_round_engine #(.N(N), .ROUNDS(1)) u_one (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (one.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] ks [ROUNDS];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [15:0] px;
    logic [15:0] py;
    logic [15:0] ex;
    logic [15:0] ey;
    int          stall_pct;
    int          bp;
    bit          keep_valid;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int s);
    return (v >> s) | (v << (16 - s));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int s);
    return (v << s) | (v >> (16 - s));
  endfunction

  // Simon32/64 key expansion from master key 0x1918_1110_0908_0100.
  task automatic gen_keys();
    logic [61:0] z0;
    logic [15:0] tmp;
    z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    ks[0] = 16'h0100;
    ks[1] = 16'h0908;
    ks[2] = 16'h1110;
    ks[3] = 16'h1918;
    for (int i = 4; i < ROUNDS; i++) begin
      tmp   = ror16(ks[i-1], 3) ^ ks[i-3];
      tmp   = tmp ^ ror16(tmp, 1);
      ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, z0[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
  endtask

  function automatic logic [31:0] model_enc(input logic [15:0] px, input logic [15:0] py);
    logic [15:0] mx;
    logic [15:0] my;
    logic [15:0] t;
    mx = px;
    my = py;
    for (int r = 0; r < ROUNDS; r++) begin
      t  = mx;
      mx = my ^ ((rol16(mx, 1) & rol16(mx, 8)) ^ rol16(mx, 2)) ^ ks[r];
      my = t;
    end
    return {mx, my};
  endfunction

  // One full block through the main engine; called just after a negedge.
  task automatic run_block(input vec_t v);
    int          wait_cyc;
    int          cyc;
    int          kidx;
    int          stalls;
    int          stall_bad;
    int          hs_bad;
    int          bp_bad;
    bit          kv;
    logic [15:0] prev_x;
    logic [15:0] prev_y;
    logic [31:0] exp_ct;

    b.in_valid = 1'b1;
    b.in_x     = v.px;
    b.in_y     = v.py;
    wait_cyc   = 0;
    while (!b.in_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!b.in_ready) check("accept_timeout", 64'(b.in_ready), 64'd1);
    exp_q.push_back({v.ex, v.ey});
    @(negedge clk);
    if (!v.keep_valid) b.in_valid = 1'b0;

    cyc       = 1;
    kidx      = 0;
    stalls    = 0;
    stall_bad = 0;
    hs_bad    = 0;
    while (!b.out_valid && cyc < 400) begin
      kv          = ($urandom_range(0, 99) >= v.stall_pct);
      b.key_valid = kv;
      b.key       = (kidx < ROUNDS) ? ks[kidx] : 16'h0000;
      prev_x      = b.out_x;
      prev_y      = b.out_y;
      if (b.in_ready !== 1'b0 || b.key_ready !== 1'b1 || b.busy !== 1'b1) hs_bad++;
      @(negedge clk);
      cyc++;
      if (kv) begin
        kidx++;
      end else begin
        stalls++;
        if (b.out_x !== prev_x || b.out_y !== prev_y) stall_bad++;
      end
    end
    check("latency", 64'(cyc), 64'(ROUNDS + 1 + stalls));
    check("keys_used", 64'(kidx), 64'(ROUNDS));
    check("stall_hold", 64'(stall_bad), 64'd0);

    // DONE with back-pressure; a presented key must not be consumed.
    b.key_valid = 1'b1;
    b.key       = 16'hFFFF;
    bp_bad      = 0;
    prev_x      = b.out_x;
    prev_y      = b.out_y;
    for (int i = 0; i < v.bp; i++) begin
      if (b.out_valid !== 1'b1 || b.out_x !== prev_x || b.out_y !== prev_y ||
          b.in_ready !== 1'b0 || b.key_ready !== 1'b0 || b.busy !== 1'b1) bp_bad++;
      @(negedge clk);
    end
    if (v.bp > 0) check("backpressure_hold", 64'(bp_bad), 64'd0);
    if (b.in_ready !== 1'b0 || b.key_ready !== 1'b0) hs_bad++;
    check("run_done_handshake", 64'(hs_bad), 64'd0);

    // Output handshake at the next edge; compare against the scoreboard.
    b.out_ready = 1'b1;
    check("out_valid", 64'(b.out_valid), 64'd1);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'(exp_q.size()));
    end else begin
      exp_ct = exp_q.pop_front();
      check("out_x", 64'(b.out_x), 64'(exp_ct[31:16]));
      check("out_y", 64'(b.out_y), 64'(exp_ct[15:0]));
    end
    b.key_valid = 1'b0;
    @(negedge clk);
    b.out_ready = 1'b0;
    check("in_ready_after_out", 64'(b.in_ready), 64'd1);
    check("busy_after_out", 64'(b.busy), 64'd0);
  endtask

  // Single-round instance: out_valid two cycles after acceptance.
  task automatic single_round_test();
    int cyc;
    one.in_valid  = 1'b1;
    one.in_x      = 16'h0001;
    one.in_y      = 16'h0000;
    one.key       = 16'h0000;
    one.key_valid = 1'b1;
    one.out_ready = 1'b0;
    check("one_in_ready", 64'(one.in_ready), 64'd1);
    @(negedge clk);
    one.in_valid = 1'b0;
    cyc = 1;
    while (!one.out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("one_latency", 64'(cyc), 64'd2);
    check("one_out_x", 64'(one.out_x), 64'h0004);
    check("one_out_y", 64'(one.out_y), 64'h0001);
    one.out_ready = 1'b1;
    one.key_valid = 1'b0;
    @(negedge clk);
    one.out_ready = 1'b0;
    check("one_idle_after", 64'(one.in_ready), 64'd1);
  endtask

  // Reset asserted for one edge with the round counter at 10.
  task automatic reset_mid_round();
    b.in_valid = 1'b1;
    b.in_x     = 16'h6565;
    b.in_y     = 16'h6877;
    check("rst_pre_accept", 64'(b.in_ready), 64'd1);
    exp_q.push_back({16'hC69B, 16'hE9BB});
    @(negedge clk);
    b.in_valid  = 1'b0;
    b.key_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b.key = ks[k];
      @(negedge clk);
    end
    rst_n       = 1'b0;
    b.key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("rst_in_ready", 64'(b.in_ready), 64'd1);
    check("rst_key_ready", 64'(b.key_ready), 64'd0);
    check("rst_out_valid", 64'(b.out_valid), 64'd0);
    check("rst_busy", 64'(b.busy), 64'd0);
    check("rst_out_xy", 64'({b.out_x, b.out_y}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    b.in_valid    = 1'b0;
    b.in_x        = '0;
    b.in_y        = '0;
    b.key_valid   = 1'b0;
    b.key         = '0;
    b.out_ready   = 1'b0;
    one.in_valid  = 1'b0;
    one.in_x      = '0;
    one.in_y      = '0;
    one.key_valid = 1'b0;
    one.key       = '0;
    one.out_ready = 1'b0;

    gen_keys();

    // {px, py, ex, ey, stall_pct, bp, keep_valid}
    vecs[0] = '{16'h6565, 16'h6877, 16'hC69B, 16'hE9BB, 0,  0,  1'b0};
    vecs[1] = '{16'h6565, 16'h6877, 16'hC69B, 16'hE9BB, 30, 10, 1'b0};
    vecs[2] = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000, 0,  0,  1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0,  0,  1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 20, 3,  1'b0};
    for (int i = 2; i < 5; i++) begin
      {vecs[i].ex, vecs[i].ey} = model_enc(vecs[i].px, vecs[i].py);
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_in_ready", 64'(b.in_ready), 64'd1);
    check("reset_key_ready", 64'(b.key_ready), 64'd0);
    check("reset_out_valid", 64'(b.out_valid), 64'd0);
    check("reset_busy", 64'(b.busy), 64'd0);
    check("reset_out_xy", 64'({b.out_x, b.out_y}), 64'd0);

    single_round_test();

    // Rows 2 and 3 run back to back with in_valid held high.
    for (int i = 0; i < 5; i++) begin
      run_block(vecs[i]);
    end

    reset_mid_round();
    run_block(vecs[0]);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_round_engine.md
# simon_round_engine

Iterative SIMON encryption datapath: accepts one 2N-bit plaintext block (x, y) over a valid/ready handshake and applies ROUNDS SIMON rounds, one per clock. Each round consumes one round key from an external key-schedule stream. It presents the ciphertext over a valid/ready output handshake. The block consumes the 1/2/8-bit left-rotation results of x on every round and sits between the block-input buffer and the ciphertext output stage.

## Interface
- N, 16: word size in bits; valid values 16, 24, 32, 48, 64.
- ROUNDS, 32: rounds per block; must be ≥1. The round counter width is clog2(ROUNDS), with a minimum of 1.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  plaintext block available.
- in_ready  output  1  engine can accept a block.
- in_x  input  N  upper plaintext word.
- in_y  input  N  lower plaintext word.
- key_valid  input  1  round key available.
- key_ready  output  1  engine consumes the key this cycle.
- key  input  N  round key k_i, presented in order i = 0..ROUNDS-1.
- out_valid  output  1  ciphertext available.
- out_ready  input  1  downstream accepts the ciphertext.
- out_x  output  N  upper ciphertext word.
- out_y  output  N  lower ciphertext word.
- busy  output  1  high in RUN or DONE.

## Operation
- Rotations: S1(v)={v[N-2:0],v[N-1]}, S2(v)={v[N-3:0],v[N-1:N-2]}, S8(v)={v[N-9:0],v[N-1:N-8]}.
- Round function: f(x) = (S1(x) & S8(x)) ^ S2(x).
- Round update, applied in one cycle: x ← y ^ f(x) ^ k; y ← x (the old x).
- FSM states:
  - **IDLE**: in_ready=1, key_ready=0, out_valid=0. On in_valid&in_ready: x←in_x, y←in_y, rnd←0, go to RUN.
  - **RUN**: in_ready=0, key_ready=1. On key_valid, apply one round and increment rnd. When key_valid is low, hold all state (stall, no round).
    - When the round executes with rnd==ROUNDS-1, go to DONE; rnd is not incremented past ROUNDS-1.
  - **DONE**: out_valid=1, out_x=x, out_y=y, key_ready=0. Outputs stay stable while out_ready is low. On out_ready, go to IDLE.
- Keys presented outside RUN are not consumed (key_ready=0). in_* is ignored outside IDLE.
- out_x/out_y drive the x/y registers at all times; they are only meaningful while out_valid=1.
- Reset (rst_n=0 at an edge) from any state, including mid-RUN or DONE:
  - state←IDLE; x, y, rnd ← 0.
  - In the cycle after the reset edge: in_ready=1, key_ready=0, out_valid=0, busy=0, out_x=out_y=0.
  - The partial block is discarded; no out_valid is produced for it.

## Timing
- Acceptance edge E0 loads the block. With key_valid held high, rounds execute on edges E1..E_ROUNDS, and out_valid rises in the cycle following E_ROUNDS.
- Latency from in handshake to out_valid: ROUNDS+1 cycles with no key stalls. Each cycle with key_valid low in RUN adds one cycle.
- Output handshake edge → IDLE; in_ready is high the next cycle. There is no same-cycle bypass from DONE to a new accept.
- Peak throughput: one block per ROUNDS+2 cycles.
- Handshake rules: in_ready, key_ready and out_valid are pure state decodes with no combinational dependence on in_valid, key_valid or out_ready.
- The round datapath is combinational from the x/y/key registers into the x/y registers: one rotation/AND/XOR level per clock, with no internal pipelining.

## Test plan
- **Single round, directed** (N=16, ROUNDS=1): in_x=0x0001, in_y=0x0000, key=0x0000 → out_x=0x0004, out_y=0x0001; out_valid 2 cycles after acceptance.
- **Known-answer test, Simon32/64** (N=16, ROUNDS=32): plaintext x=0x6565, y=0x6877; the bench model's key schedule generates the round keys from key 0x1918_1110_0908_0100 → out_x=0xC69B, out_y=0xE9BB.
- **Key stalls**: same KAT with key_valid randomly deasserted ~30% of cycles → identical ciphertext. Latency equals 33 plus the number of stalled RUN cycles; x/y are unchanged on stalled cycles.
- **Output back-pressure**: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_x/out_y stable, in_ready=0, key_ready=0. After out_ready=1 for one cycle → in_ready=1 next cycle.
- **Reset mid-round**: assert rst_n=0 for one edge at rnd=10 → next cycle state IDLE, in_ready=1, out_valid=0, busy=0, out_x=out_y=0. A following KAT run then produces the correct ciphertext.
- **Back-to-back blocks**: in_valid held high with two different plaintexts and out_ready=1 → both ciphertexts match the model. The second block is accepted exactly 1 cycle after the first output handshake, and in_ready=0 throughout RUN/DONE.
